// File: rtl/sdram_arb_pkg.sv
// Shared constants for the frame-buffer SDRAM arbiter: op codes, FSM encoding
// and default geometry.
package sdram_arb_pkg;

  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_FIFO_DEPTH  = 1024;
  localparam int DEF_REF_PERIOD  = 780;

  localparam int ADDR_W  = 22;
  localparam int USEDW_W = 11;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_REF  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer plus a saturating count of refreshes still owed.
// The timer only advances while the SDRAM is initialised.
module sdram_ref_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       ref_ack_i,
  output logic [1:0] ref_pend_o
);

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(REF_PERIOD - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    pend_q, pend_d;
  logic          wrap;

  always_comb begin
    wrap   = en_i && (tmr_q == T_LAST);
    tmr_d  = tmr_q;
    pend_d = pend_q;
    if (en_i) tmr_d = wrap ? '0 : tmr_q + 1'b1;
    // A wrap and an acknowledge in the same cycle cancel out.
    if (wrap && !ref_ack_i) begin
      if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
    end else if (ref_ack_i && !wrap) begin
      if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= '0;
      pend_q <= 2'd0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pend_o = pend_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates refresh, frame-write and frame-read bursts onto one SDRAM command
// port and manages the double-buffered frame banks.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int REF_PERIOD  = DEF_REF_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic [USEDW_W-1:0] wr_fifo_usedw,
  input  logic [USEDW_W-1:0] rd_fifo_usedw,
  input  logic               rd_enable,
  input  logic               cmd_rdy,
  input  logic               cmd_done,
  output logic               cmd_vld,
  output logic [1:0]         cmd_op,
  output logic [1:0]         cmd_bank,
  output logic [ADDR_W-1:0]  cmd_addr,
  output logic               wr_bank,
  output logic               rd_bank,
  output logic               frame_drop
);

  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
  localparam logic [USEDW_W:0]  WR_THR  = (USEDW_W + 1)'(BURST_LEN);
  localparam logic [USEDW_W:0]  RD_THR  = (USEDW_W + 1)'(FIFO_DEPTH - BURST_LEN);

  state_e            state_q, state_d;
  op_e               cur_op_q, cur_op_d;
  logic [1:0]        cur_bank_q, cur_bank_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic              wr_full_q, wr_full_d;
  logic              last_rd_q, last_rd_d;
  logic              frame_drop_q, frame_drop_d;

  logic [1:0]        ref_pend;
  logic              elig_ref, elig_wr, elig_rd, any_elig, pick_wr;
  logic              accept, done, ref_ack;
  logic [ADDR_W-1:0] wr_nxt, rd_nxt;
  logic              wr_wrap, rd_wrap;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref (
    .clk        (clk),
    .rst        (rst),
    .en_i       (init_done),
    .ref_ack_i  (ref_ack),
    .ref_pend_o (ref_pend)
  );

  assign elig_ref = (ref_pend != 2'd0);
  assign elig_wr  = ({1'b0, wr_fifo_usedw} >= WR_THR);
  assign elig_rd  = rd_enable && ({1'b0, rd_fifo_usedw} <= RD_THR);
  assign any_elig = elig_ref || elig_wr || elig_rd;
  // On a write/read tie the side that was not served last wins.
  assign pick_wr  = elig_wr && (!elig_rd || last_rd_q);

  assign accept  = (state_q == ST_ISSUE) && cmd_rdy;
  assign done    = (state_q == ST_WAIT) && cmd_done;
  assign ref_ack = accept && (cur_op_q == OP_REF);

  assign wr_nxt  = wr_addr_q + BURST_A;
  assign rd_nxt  = rd_addr_q + BURST_A;
  assign wr_wrap = done && (cur_op_q == OP_WR) && (wr_nxt == FRAME_A);
  assign rd_wrap = done && (cur_op_q == OP_RD) && (rd_nxt == FRAME_A);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (init_done) state_d = ST_ARB;
      ST_ARB: begin
        if (!init_done)    state_d = ST_IDLE;
        else if (any_elig) state_d = ST_ISSUE;
      end
      ST_ISSUE: if (cmd_rdy) state_d = ST_WAIT;
      ST_WAIT:  if (cmd_done) state_d = init_done ? ST_ARB : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_vld  = (state_q == ST_ISSUE);
    cmd_op   = OP_NONE;
    cmd_bank = 2'd0;
    cmd_addr = '0;
    if (cmd_vld) begin
      cmd_op   = cur_op_q;
      cmd_bank = cur_bank_q;
      cmd_addr = cur_addr_q;
    end
  end

  // Command latched at selection so it stays stable through ISSUE and WAIT.
  always_comb begin
    cur_op_d   = cur_op_q;
    cur_bank_d = cur_bank_q;
    cur_addr_d = cur_addr_q;
    last_rd_d  = last_rd_q;
    if ((state_q == ST_ARB) && init_done && any_elig) begin
      if (elig_ref) begin
        cur_op_d   = OP_REF;
        cur_bank_d = 2'd0;
        cur_addr_d = '0;
      end else if (pick_wr) begin
        cur_op_d   = OP_WR;
        cur_bank_d = {1'b0, wr_bank_q};
        cur_addr_d = wr_addr_q;
        last_rd_d  = 1'b0;
      end else begin
        cur_op_d   = OP_RD;
        cur_bank_d = {1'b0, rd_bank_q};
        cur_addr_d = rd_addr_q;
        last_rd_d  = 1'b1;
      end
    end
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_full_d    = wr_full_q;
    frame_drop_d = 1'b0;
    if (done && (cur_op_q == OP_WR)) wr_addr_d = wr_wrap ? '0 : wr_nxt;
    if (done && (cur_op_q == OP_RD)) rd_addr_d = rd_wrap ? '0 : rd_nxt;
    // Write completion is applied before the read swap decision.
    if (wr_wrap) begin
      if (wr_full_q) frame_drop_d = 1'b1;
      else           wr_full_d    = 1'b1;
    end
    if (rd_wrap && wr_full_d) begin
      wr_bank_d = rd_bank_q;
      rd_bank_d = wr_bank_q;
      wr_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_op_q     <= OP_NONE;
      cur_bank_q   <= 2'd0;
      cur_addr_q   <= '0;
      last_rd_q    <= 1'b1;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      wr_full_q    <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      cur_op_q     <= cur_op_d;
      cur_bank_q   <= cur_bank_d;
      cur_addr_q   <= cur_addr_d;
      last_rd_q    <= last_rd_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_full_q    <= wr_full_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a command-engine responder records every
// accepted command; the main sequence compares them against expected queues.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  bank;
    logic [21:0] addr;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst, init_done, rd_enable, cmd_rdy, cmd_done;
  logic [10:0] wr_fifo_usedw, rd_fifo_usedw;
  logic        cmd_vld, wr_bank, rd_bank, frame_drop;
  logic [1:0]  cmd_op, cmd_bank;
  logic [21:0] cmd_addr;

  cmd_t exp_q[$];
  cmd_t act_q[$];
  int   tests = 0, fails = 0;
  int   data_cnt = 0, vld_cnt = 0, drop_cnt = 0;
  int   force_req = 0, force_seen = 0;
  bit   auto_done = 1'b0, done_pending = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .BURST_LEN   (4),
    .FRAME_WORDS (16),
    .FIFO_DEPTH  (16),
    .REF_PERIOD  (50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_done     (init_done),
    .wr_fifo_usedw (wr_fifo_usedw),
    .rd_fifo_usedw (rd_fifo_usedw),
    .rd_enable     (rd_enable),
    .cmd_rdy       (cmd_rdy),
    .cmd_done      (cmd_done),
    .cmd_vld       (cmd_vld),
    .cmd_op        (cmd_op),
    .cmd_bank      (cmd_bank),
    .cmd_addr      (cmd_addr),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .frame_drop    (frame_drop)
  );

  // Command engine: records handshakes, answers with cmd_done one cycle later.
  initial begin
    cmd_t c;
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (done_pending || (force_req != force_seen)) begin
        cmd_done     = 1'b1;
        done_pending = 1'b0;
        force_seen   = force_req;
      end
      if (cmd_vld) vld_cnt++;
      if (frame_drop) drop_cnt++;
      if (cmd_vld && cmd_rdy) begin
        c.op   = cmd_op;
        c.bank = cmd_bank;
        c.addr = cmd_addr;
        act_q.push_back(c);
        if (cmd_op != OP_REF) data_cnt++;
        if (auto_done) done_pending = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] bank, input logic [21:0] addr);
    cmd_t c;
    c.op   = op;
    c.bank = bank;
    c.addr = addr;
    exp_q.push_back(c);
  endtask

  task automatic wait_cnt(input int target, input string tag);
    int n = 0;
    while (data_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, 32'(data_cnt >= target), 1);
  endtask

  // Refreshes may interleave anywhere; data commands must match in order.
  task automatic drain(input string tag);
    cmd_t a, e;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      if (a.op == OP_REF) begin
        chk({tag, "_ref_bank_addr"}, 32'({a.bank, a.addr}), 0);
      end else if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_op"}, 32'(a.op), 0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_op"},   32'(a.op),   32'(e.op));
        chk({tag, "_bank"}, 32'(a.bank), 32'(e.bank));
        chk({tag, "_addr"}, 32'(a.addr), 32'(e.addr));
      end
    end
    chk({tag, "_missing"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; init_done = 1'b0; auto_done = 1'b0;
    wr_fifo_usedw = '0; rd_fifo_usedw = '0; rd_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(dut.state_q), 32'(ST_IDLE));
    chk({tag, "_vld"},     32'(cmd_vld), 0);
    chk({tag, "_op"},      32'(cmd_op), 0);
    chk({tag, "_bank"},    32'(cmd_bank), 0);
    chk({tag, "_addr"},    32'(cmd_addr), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 1);
    chk({tag, "_drop"},    32'(frame_drop), 0);
    chk({tag, "_refpend"}, 32'(dut.ref_pend), 0);
    chk({tag, "_wr_addr"}, 32'(dut.wr_addr_q), 0);
  endtask

  initial begin
    int base, vbase, dbase, n;
    cmd_rdy = 1'b0;
    do_reset();
    chk_reset_outputs("reset");

    // Single writes: one-cycle latency from ARB, address advances by a burst.
    push(OP_WR, 2'd0, 22'd0);
    push(OP_WR, 2'd0, 22'd4);
    base = data_cnt;
    cmd_rdy = 1'b1; auto_done = 1'b1; wr_fifo_usedw = 11'd4; init_done = 1'b1;
    @(negedge clk);
    chk("lat_in_arb", 32'(dut.state_q), 32'(ST_ARB));
    chk("lat_vld_low", 32'(cmd_vld), 0);
    @(negedge clk);
    chk("lat_vld_high", 32'(cmd_vld), 1);
    chk("lat_op_wr", 32'(cmd_op), 32'(OP_WR));
    wait_cnt(base + 2, "wr2");
    wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    drain("wr");

    // Round robin: last served was a write, so the read wins first.
    push(OP_RD, 2'd1, 22'd0);  push(OP_WR, 2'd0, 22'd8);
    push(OP_RD, 2'd1, 22'd4);  push(OP_WR, 2'd0, 22'd12);
    push(OP_RD, 2'd1, 22'd8);  push(OP_WR, 2'd0, 22'd0);
    base = data_cnt;
    rd_enable = 1'b1; rd_fifo_usedw = '0; wr_fifo_usedw = 11'd4;
    wait_cnt(base + 6, "rr6");
    rd_enable = 1'b0; wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    drain("rr");
    chk("rr_wr_full", 32'(dut.wr_full_q), 1);

    // Eligibility boundaries: write needs a full burst, read needs room for one.
    do_reset();
    cmd_rdy = 1'b1; auto_done = 1'b1; init_done = 1'b1;
    rd_enable = 1'b1; rd_fifo_usedw = 11'd13; wr_fifo_usedw = 11'd3;
    vbase = vld_cnt;
    repeat (6) @(negedge clk);
    chk("bnd_no_issue", 32'(vld_cnt - vbase), 0);
    push(OP_RD, 2'd1, 22'd0);
    base = data_cnt;
    rd_fifo_usedw = 11'd12;
    wait_cnt(base + 1, "bnd_rd");
    rd_enable = 1'b0; wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    drain("bnd");

    // Refresh owed while write and read are both waiting goes first.
    do_reset();
    cmd_rdy = 1'b1; auto_done = 1'b0; init_done = 1'b1; wr_fifo_usedw = 11'd4;
    push(OP_WR, 2'd0, 22'd0);
    base = data_cnt;
    wait_cnt(base + 1, "ref_w0");
    wr_fifo_usedw = '0;
    repeat (60) @(negedge clk);
    chk("ref_pend_one", 32'(dut.ref_pend), 1);
    drain("ref_pre");
    push(OP_RD, 2'd1, 22'd0);
    push(OP_WR, 2'd0, 22'd4);
    base = data_cnt;
    rd_enable = 1'b1; rd_fifo_usedw = '0; wr_fifo_usedw = 11'd4; auto_done = 1'b1;
    @(posedge clk); #1;
    force_req++;
    wait_cnt(base + 2, "ref_resume");
    rd_enable = 1'b0; wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    chk("ref_first", 32'(act_q[0].op), 32'(OP_REF));
    drain("ref");

    // Back-pressure: command held stable while cmd_rdy is low.
    do_reset();
    cmd_rdy = 1'b0; auto_done = 1'b1; init_done = 1'b1; wr_fifo_usedw = 11'd4;
    n = 0;
    while (!cmd_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld_seen", 32'(cmd_vld), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld",  32'(cmd_vld), 1);
      chk("stall_op",   32'(cmd_op), 32'(OP_WR));
      chk("stall_addr", 32'({cmd_bank, cmd_addr}), 0);
    end
    push(OP_WR, 2'd0, 22'd0);
    base = data_cnt;
    wr_fifo_usedw = '0;
    @(posedge clk); #1;
    cmd_rdy = 1'b1;
    wait_cnt(base + 1, "stall_acc");
    repeat (10) @(negedge clk);
    chk("stall_one_accept", 32'(data_cnt - base), 1);
    drain("stall");

    // Bank swap on read wrap, then frame drop when a full frame is overwritten.
    do_reset();
    cmd_rdy = 1'b1; auto_done = 1'b1; init_done = 1'b1;
    dbase = drop_cnt;
    for (int i = 0; i < 4; i++) push(OP_WR, 2'd0, 22'(4 * i));
    base = data_cnt;
    wr_fifo_usedw = 11'd4;
    wait_cnt(base + 4, "fr_w4");
    wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    chk("fr_no_drop_yet", 32'(drop_cnt - dbase), 0);
    chk("fr_full_set", 32'(dut.wr_full_q), 1);
    for (int i = 0; i < 4; i++) push(OP_RD, 2'd1, 22'(4 * i));
    base = data_cnt;
    rd_enable = 1'b1;
    wait_cnt(base + 4, "fr_r4");
    rd_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("fr_swap_wr_bank", 32'(wr_bank), 1);
    chk("fr_swap_rd_bank", 32'(rd_bank), 0);
    chk("fr_full_clr", 32'(dut.wr_full_q), 0);
    for (int i = 0; i < 8; i++) push(OP_WR, 2'd1, 22'(4 * (i % 4)));
    base = data_cnt;
    wr_fifo_usedw = 11'd4;
    wait_cnt(base + 8, "fr_w8");
    wr_fifo_usedw = '0;
    repeat (4) @(negedge clk);
    chk("fr_drop_once", 32'(drop_cnt - dbase), 1);
    chk("fr_wr_bank_kept", 32'(wr_bank), 1);
    chk("fr_full_kept", 32'(dut.wr_full_q), 1);
    drain("fr");

    // Reset in the middle of a command, then idle with init_done low.
    auto_done = 1'b0; wr_fifo_usedw = 11'd4;
    n = 0;
    while (dut.state_q != ST_WAIT && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_in_wait", 32'(dut.state_q), 32'(ST_WAIT));
    rst = 1'b1; init_done = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    vbase = vld_cnt;
    repeat (200) @(negedge clk);
    chk("noinit_no_vld", 32'(vld_cnt - vbase), 0);
    act_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL take these parameters: BURST_LEN, default 256, words per read/write burst.
REQ-002 The block SHALL take these parameters: FRAME_WORDS, default 307200, words per frame; must be a multiple of BURST_LEN.
REQ-003 The block SHALL take these parameters: FIFO_DEPTH, default 1024, depth of the read-side FIFO.
REQ-004 The block SHALL take these parameters: REF_PERIOD, default 780, clk cycles between refresh requests.
REQ-005 The block SHALL have these ports: clk  in  1  100 MHz controller clock.
REQ-006 The block SHALL have these ports: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have these ports: init_done  in  1  SDRAM power-up initialisation complete.
REQ-008 The block SHALL have these ports: wr_fifo_usedw  in  11  words waiting in the write FIFO.
REQ-009 The block SHALL have these ports: rd_fifo_usedw  in  11  words held in the read FIFO.
REQ-010 The block SHALL have these ports: rd_enable  in  1  display side requests data.
REQ-011 The block SHALL have these ports: cmd_rdy  in  1  command engine accepts a command.
REQ-012 The block SHALL have these ports: cmd_done  in  1  one-cycle pulse when the accepted command completes.
REQ-013 The block SHALL have these ports: cmd_vld  out  1  command valid.
REQ-014 The block SHALL have these ports: cmd_op  out  2  operation code: 01 write, 10 read, 11 refresh, 00 none.
REQ-015 The block SHALL have these ports: cmd_bank  out  2  SDRAM bank.
REQ-016 The block SHALL have these ports: cmd_addr  out  22  burst-aligned word address within the bank.
REQ-017 The block SHALL have these ports: wr_bank  out  1  frame buffer currently being written.
REQ-018 The block SHALL have these ports: rd_bank  out  1  frame buffer currently being read.
REQ-019 The block SHALL have these ports: frame_drop  out  1  one-cycle pulse when a completed write frame is overwritten.

Function
REQ-020 The FSM SHALL have the states IDLE, ARB, ISSUE and WAIT.
REQ-021 In IDLE the FSM SHALL move to ARB in the cycle after init_done is sampled high.
REQ-022 In ARB the FSM SHALL select one request per cycle and go to ISSUE; if no request is eligible it SHALL stay in ARB.
REQ-023 Refresh eligibility: ref_pend > 0.
REQ-024 Write eligibility: wr_fifo_usedw >= BURST_LEN.
REQ-025 Read eligibility: rd_enable = 1 and rd_fifo_usedw <= FIFO_DEPTH - BURST_LEN.
REQ-026 Priority SHALL be refresh first; between write and read it SHALL be round-robin, with the non-last-served side winning a tie.
REQ-027 In ISSUE, cmd_vld SHALL be 1 and cmd_op/cmd_bank/cmd_addr SHALL be held stable until a cycle in which cmd_vld and cmd_rdy are both 1.
REQ-028 On that accepting cycle the FSM SHALL move to WAIT; the next cycle cmd_vld SHALL be 0.
REQ-029 In WAIT the FSM SHALL return to ARB on cmd_done; cmd_done in any other state SHALL be ignored.
REQ-030 Latency: cmd_vld SHALL rise exactly one cycle after ARB sees an eligible request.
REQ-031 Refresh timer: counts 0..REF_PERIOD-1 only while init_done = 1 and increments ref_pend on wrap.
REQ-032 ref_pend SHALL saturate at 3 and decrement on acceptance of a refresh command.
REQ-033 If a wrap and a refresh acceptance occur in the same cycle, ref_pend SHALL be unchanged.
REQ-034 For a write, cmd_bank SHALL be {1'b0, wr_bank} and cmd_addr SHALL be wr_addr.
REQ-035 For a read, cmd_bank SHALL be {1'b0, rd_bank} and cmd_addr SHALL be rd_addr.
REQ-036 For a refresh, cmd_bank and cmd_addr SHALL be 0.
REQ-037 wr_addr SHALL advance by BURST_LEN on cmd_done of a write; rd_addr SHALL advance by BURST_LEN on cmd_done of a read.
REQ-038 Either address SHALL wrap to 0 when it reaches FRAME_WORDS.
REQ-039 On a write wrap, if wr_full = 0 the block SHALL set wr_full.
REQ-040 On a write wrap, if wr_full = 1 the block SHALL pulse frame_drop and leave wr_full at 1; the same bank is rewritten.
REQ-041 On a read wrap, if wr_full = 1 the block SHALL swap wr_bank and rd_bank and clear wr_full.
REQ-042 On a read wrap, if wr_full = 0 the block SHALL re-read the same bank.
REQ-043 Simultaneous write wrap and read wrap with wr_full = 0: the write completion SHALL apply first, so the swap happens in that cycle and wr_full ends at 0.
REQ-044 If init_done falls, the block SHALL finish any accepted command and then go to IDLE, without clearing addresses.

Reset
REQ-045 On rst, the state SHALL be IDLE.
REQ-046 On rst, cmd_vld, cmd_op, cmd_bank, cmd_addr, frame_drop, wr_addr, rd_addr, ref_pend, the timer and wr_full SHALL all be 0.
REQ-047 On rst, wr_bank SHALL be 0 and rd_bank SHALL be 1, and last-served SHALL be read.
REQ-048 rst SHALL take effect mid-command, with no wait for cmd_done.

Structure
REQ-049 Package sdram_arb_pkg SHALL hold the op-code constants, the FSM state encoding and the default parameter values.
REQ-050 The refresh timer and ref_pend counter SHALL be sub-module sdram_ref_timer.

Verification
REQ-051 Bench parameters SHALL be BURST_LEN=4, FRAME_WORDS=16, FIFO_DEPTH=16, REF_PERIOD=50.
REQ-052 Scenario: init_done=1, wr_usedw=4, rd_enable=0, cmd_rdy=1 -> cmd_vld one cycle after ARB, cmd_op=01, cmd_addr=0, bank=0; after cmd_done the next write has cmd_addr=4.
REQ-053 Scenario: write and read both eligible for 6 bursts with immediate cmd_done -> ops alternate 10,01,10,01,10,01.
REQ-054 Scenario: ref_pend=1 while write and read are eligible -> refresh issued first with cmd_op=11, then write/read resume.
REQ-055 Scenario: cmd_rdy held 0 for 5 cycles -> cmd_vld, cmd_op and cmd_addr stable throughout; one command accepted when cmd_rdy rises.
REQ-056 Scenario: 4 write bursts then 4 read bursts -> wr_bank=1, rd_bank=0 after the read wrap; a further 8 write bursts with no reads -> frame_drop pulses once.
REQ-057 Scenario: rst asserted in WAIT -> next cycle all outputs at reset values and state IDLE; 200 cycles with init_done=0 -> no cmd_vld.
